// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard for the decode stage: per-register pending-write
// counters gate issue into ID/EX and are released on writeback or flush.
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                id_valid_ip,
    input  logic [6:0]          id_opcode_ip,
    input  logic [4:0]          id_rs1_ip,
    input  logic [4:0]          id_rs2_ip,
    input  logic [4:0]          id_rd_ip,
    input  logic                id_writes_rd_ip,
    input  logic                wb_valid_ip,
    input  logic [4:0]          wb_rd_ip,
    input  logic                flush_en_ip,
    input  logic                flush_writes_ip,
    input  logic [4:0]          flush_rd_ip,
    output logic                stall_op,
    output logic                issue_op,
    output logic [NUM_REGS-1:0] busy_vec_op,
    output logic                err_op
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic [CNT_W-1:0]    r_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic                r_err;

    logic [CNT_W-1:0]    w_cnt_next [NUM_REGS];
    logic [NUM_REGS-1:0] w_uflow;
    logic                w_rs1_used;
    logic                w_rs2_used;
    logic                w_rs1_hazard;
    logic                w_rs2_hazard;
    logic                w_rd_full;
    logic                w_stall;
    logic                w_issue;

    always_comb begin
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        case (id_opcode_ip)
            OPC_OP, OPC_STORE, OPC_BRANCH: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            OPC_OPIMM, OPC_LOAD, OPC_JALR: w_rs1_used = 1'b1;
            default: ;
        endcase
    end

    // Hazards use the registered counters only; a same-cycle writeback does not bypass.
    assign w_rs1_hazard = w_rs1_used && (id_rs1_ip != 5'd0) && (r_cnt[id_rs1_ip] != '0);
    assign w_rs2_hazard = w_rs2_used && (id_rs2_ip != 5'd0) && (r_cnt[id_rs2_ip] != '0);
    assign w_rd_full    = id_writes_rd_ip && (id_rd_ip != 5'd0) && (r_cnt[id_rd_ip] == {CNT_W{1'b1}});

    assign w_stall = id_valid_ip & ~flush_en_ip & ~reset & (w_rs1_hazard | w_rs2_hazard | w_rd_full);
    assign w_issue = id_valid_ip & ~w_stall & ~flush_en_ip & ~reset;

    assign w_cnt_next[0] = '0;
    assign w_uflow[0]    = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
            localparam logic [4:0] IDX = 5'(gi);
            logic             w_inc;
            logic [1:0]       w_dec;
            logic [CNT_W:0]   w_up;
            logic [CNT_W:0]   w_dec_ext;

            assign w_inc = w_issue & id_writes_rd_ip & (id_rd_ip == IDX);
            assign w_dec = {1'b0, wb_valid_ip & (wb_rd_ip == IDX)}
                         + {1'b0, flush_en_ip & flush_writes_ip & (flush_rd_ip == IDX)};
            assign w_up      = {1'b0, r_cnt[gi]} + (CNT_W+1)'(w_inc);
            assign w_dec_ext = (CNT_W+1)'(w_dec);

            // Net of up to one reservation and two releases; negative results clamp to zero.
            assign w_uflow[gi]    = (w_up < w_dec_ext);
            assign w_cnt_next[gi] = w_uflow[gi] ? '0 : CNT_W'(w_up - w_dec_ext);
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= '0;
            end
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i]  <= w_cnt_next[i];
                r_busy[i] <= |w_cnt_next[i];
            end
            r_err <= r_err | (|w_uflow);
        end
    end

    assign stall_op    = w_stall;
    assign issue_op    = w_issue;
    assign busy_vec_op = r_busy;
    assign err_op      = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hand-computed expectations checked with
// immediate assertions, one report line per transaction.
module tb_reg_scoreboard;

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid_ip;
    logic [6:0]  id_opcode_ip;
    logic [4:0]  id_rs1_ip;
    logic [4:0]  id_rs2_ip;
    logic [4:0]  id_rd_ip;
    logic        id_writes_rd_ip;
    logic        wb_valid_ip;
    logic [4:0]  wb_rd_ip;
    logic        flush_en_ip;
    logic        flush_writes_ip;
    logic [4:0]  flush_rd_ip;
    logic        stall_op;
    logic        issue_op;
    logic [31:0] busy_vec_op;
    logic        err_op;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_busy;

    always #5 clock = ~clock;

    reg_scoreboard #(.NUM_REGS(32), .CNT_W(2)) dut (
        .clock           (clock),
        .reset           (reset),
        .id_valid_ip     (id_valid_ip),
        .id_opcode_ip    (id_opcode_ip),
        .id_rs1_ip       (id_rs1_ip),
        .id_rs2_ip       (id_rs2_ip),
        .id_rd_ip        (id_rd_ip),
        .id_writes_rd_ip (id_writes_rd_ip),
        .wb_valid_ip     (wb_valid_ip),
        .wb_rd_ip        (wb_rd_ip),
        .flush_en_ip     (flush_en_ip),
        .flush_writes_ip (flush_writes_ip),
        .flush_rd_ip     (flush_rd_ip),
        .stall_op        (stall_op),
        .issue_op        (issue_op),
        .busy_vec_op     (busy_vec_op),
        .err_op          (err_op)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic wr);
        id_valid_ip     = v;
        id_opcode_ip    = op;
        id_rs1_ip       = rs1;
        id_rs2_ip       = rs2;
        id_rd_ip        = rd;
        id_writes_rd_ip = wr;
        #1;
        $display("txn id v=%0d op=%b rs1=%0d rs2=%0d rd=%0d wr=%0d -> stall=%0d issue=%0d",
                 v, op, rs1, rs2, rd, wr, stall_op, issue_op);
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd);
        wb_valid_ip = v;
        wb_rd_ip    = rd;
        #1;
        $display("txn wb v=%0d rd=%0d", v, rd);
    endtask

    task automatic set_flush(input logic en, input logic wr, input logic [4:0] rd);
        flush_en_ip     = en;
        flush_writes_ip = wr;
        flush_rd_ip     = rd;
        #1;
        $display("txn flush en=%0d wr=%0d rd=%0d", en, wr, rd);
    endtask

    initial begin
        reset = 1'b1;
        set_wb(1'b0, 5'd0);
        set_flush(1'b0, 1'b0, 5'd0);
        set_id(1'b1, OPC_OPIMM, 5'd0, 5'd0, 5'd5, 1'b1);
        chk("rst_issue", {31'd0, issue_op}, 32'd0);
        chk("rst_stall", {31'd0, stall_op}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        set_id(1'b0, OPC_OPIMM, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("idle_busy", busy_vec_op, 32'd0);
        chk("idle_stall", {31'd0, stall_op}, 32'd0);
        chk("idle_err", {31'd0, err_op}, 32'd0);

        // ADDI x5
        set_id(1'b1, OPC_OPIMM, 5'd0, 5'd0, 5'd5, 1'b1);
        chk("addi5_issue", {31'd0, issue_op}, 32'd1);
        tick();
        set_id(1'b0, OPC_OPIMM, 5'd0, 5'd0, 5'd0, 1'b0);
        exp_busy = 32'h0000_0020;
        chk("addi5_busy", busy_vec_op, exp_busy);

        // RAW: ADD x3,x1,x2 then ADD x4,x3,x3
        set_id(1'b1, OPC_OP, 5'd1, 5'd2, 5'd3, 1'b1);
        chk("add3_issue", {31'd0, issue_op}, 32'd1);
        tick();
        exp_busy = exp_busy | 32'h0000_0008;
        chk("add3_busy", busy_vec_op, exp_busy);
        set_id(1'b1, OPC_OP, 5'd3, 5'd3, 5'd4, 1'b1);
        chk("raw_stall", {31'd0, stall_op}, 32'd1);
        chk("raw_noissue", {31'd0, issue_op}, 32'd0);
        tick();
        chk("raw_stall2", {31'd0, stall_op}, 32'd1);
        set_wb(1'b1, 5'd3);
        chk("raw_wb_same_cycle", {31'd0, stall_op}, 32'd1);
        tick();
        set_wb(1'b0, 5'd0);
        exp_busy = exp_busy & ~32'h0000_0008;
        chk("raw_clear_busy", busy_vec_op, exp_busy);
        chk("raw_unstall", {31'd0, stall_op}, 32'd0);
        chk("raw_issue", {31'd0, issue_op}, 32'd1);
        tick();
        set_id(1'b0, OPC_OPIMM, 5'd0, 5'd0, 5'd0, 1'b0);
        exp_busy = exp_busy | 32'h0000_0010;
        chk("add4_busy", busy_vec_op, exp_busy);

        // Overflow guard on x7
        set_id(1'b1, OPC_OPIMM, 5'd0, 5'd0, 5'd7, 1'b1);
        chk("ovf_issue1", {31'd0, issue_op}, 32'd1);
        tick();
        chk("ovf_issue2", {31'd0, issue_op}, 32'd1);
        tick();
        chk("ovf_issue3", {31'd0, issue_op}, 32'd1);
        tick();
        exp_busy = exp_busy | 32'h0000_0080;
        chk("ovf_busy", busy_vec_op, exp_busy);
        chk("ovf_stall", {31'd0, stall_op}, 32'd1);
        chk("ovf_noissue", {31'd0, issue_op}, 32'd0);
        set_wb(1'b1, 5'd7);
        chk("ovf_wb_same_cycle", {31'd0, stall_op}, 32'd1);
        tick();
        set_wb(1'b0, 5'd0);
        chk("ovf_reissue", {31'd0, issue_op}, 32'd1);
        tick();
        chk("ovf_full_again", {31'd0, stall_op}, 32'd1);
        set_id(1'b0, OPC_OPIMM, 5'd0, 5'd0, 5'd0, 1'b0);
        set_wb(1'b1, 5'd7);
        tick();
        tick();
        chk("ovf_drain2_busy", busy_vec_op, exp_busy);
        tick();
        set_wb(1'b0, 5'd0);
        exp_busy = exp_busy & ~32'h0000_0080;
        chk("ovf_drain3_busy", busy_vec_op, exp_busy);
        chk("ovf_err", {31'd0, err_op}, 32'd0);

        // Simultaneous issue/wb/flush on x9 with cnt[9]=2
        set_id(1'b1, OPC_OPIMM, 5'd0, 5'd0, 5'd9, 1'b1);
        tick();
        tick();
        set_wb(1'b1, 5'd9);
        set_flush(1'b1, 1'b1, 5'd9);
        chk("sim_noissue", {31'd0, issue_op}, 32'd0);
        chk("sim_nostall", {31'd0, stall_op}, 32'd0);
        tick();
        set_wb(1'b0, 5'd0);
        set_flush(1'b0, 1'b0, 5'd0);
        set_id(1'b0, OPC_OPIMM, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("sim_busy", busy_vec_op, exp_busy);
        chk("sim_err", {31'd0, err_op}, 32'd0);

        // Flush suppresses a real hazard (x4 busy) and drops the reservation
        set_id(1'b1, OPC_OP, 5'd4, 5'd5, 5'd6, 1'b1);
        chk("hz_stall", {31'd0, stall_op}, 32'd1);
        set_flush(1'b1, 1'b0, 5'd0);
        chk("fl_nostall", {31'd0, stall_op}, 32'd0);
        chk("fl_noissue", {31'd0, issue_op}, 32'd0);
        tick();
        set_flush(1'b0, 1'b0, 5'd0);
        set_id(1'b0, OPC_OPIMM, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("fl_busy", busy_vec_op, exp_busy);

        // JAL ignores its rs fields
        set_id(1'b1, OPC_JAL, 5'd4, 5'd5, 5'd1, 1'b1);
        chk("jal_nostall", {31'd0, stall_op}, 32'd0);
        chk("jal_issue", {31'd0, issue_op}, 32'd1);
        tick();
        set_id(1'b0, OPC_OPIMM, 5'd0, 5'd0, 5'd0, 1'b0);
        exp_busy = exp_busy | 32'h0000_0002;
        chk("jal_busy", busy_vec_op, exp_busy);

        // Underflow on x12
        set_wb(1'b1, 5'd12);
        tick();
        set_wb(1'b0, 5'd0);
        chk("uf_busy", busy_vec_op, exp_busy);
        chk("uf_err", {31'd0, err_op}, 32'd1);
        tick();
        tick();
        chk("uf_err_sticky", {31'd0, err_op}, 32'd1);

        // x0 never tracked
        set_id(1'b1, OPC_OP, 5'd0, 5'd0, 5'd0, 1'b1);
        chk("x0_nostall", {31'd0, stall_op}, 32'd0);
        chk("x0_issue", {31'd0, issue_op}, 32'd1);
        tick();
        set_id(1'b0, OPC_OPIMM, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("x0_busy", busy_vec_op, exp_busy);
        set_wb(1'b1, 5'd0);
        set_flush(1'b1, 1'b1, 5'd0);
        tick();
        set_wb(1'b0, 5'd0);
        set_flush(1'b0, 1'b0, 5'd0);
        chk("x0_release_busy", busy_vec_op, exp_busy);

        // Reset mid-stall with cnt[3]=2
        set_id(1'b1, OPC_OPIMM, 5'd0, 5'd0, 5'd3, 1'b1);
        tick();
        tick();
        set_id(1'b1, OPC_OP, 5'd3, 5'd3, 5'd8, 1'b1);
        chk("rs_stall", {31'd0, stall_op}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rs_hold_stall", {31'd0, stall_op}, 32'd0);
        chk("rs_hold_issue", {31'd0, issue_op}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rs_busy", busy_vec_op, 32'd0);
        chk("rs_err", {31'd0, err_op}, 32'd0);
        chk("rs_stall_after", {31'd0, stall_op}, 32'd0);
        chk("rs_issue_after", {31'd0, issue_op}, 32'd1);
        tick();
        set_id(1'b0, OPC_OPIMM, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("rs_busy8", busy_vec_op, 32'h0000_0100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
